// File: rtl/packet_pkg.sv
// Shared packet field layout, packet types and egress FSM states for the switch datapath.
// Packets are at least 16 bits: source[3:0], target[7:4], type[9:8], payload[15:10].
package packet_pkg;

  localparam int unsigned SRC_LSB  = 0;
  localparam int unsigned TGT_LSB  = 4;
  localparam int unsigned TYPE_LSB = 8;
  localparam int unsigned PAY_LSB  = 10;
  localparam int unsigned PORTS    = 4;

  typedef enum logic [1:0] {
    P_DATA = 2'd0,
    P_CTRL = 2'd1,
    P_RSV  = 2'd2,
    P_BDP  = 2'd3   // broadcast: accepted by every egress regardless of target
  } p_type;

  typedef enum logic {
    E_IDLE = 1'b0,
    E_SEND = 1'b1
  } egress_state_t;

endpackage

// File: rtl/port_egress_if.sv
// Crossbar-to-egress and egress-to-downstream signal bundle.
// slave = the egress block, master = crossbar/downstream environment.
interface port_egress_if #(
    parameter int unsigned PACKET_WIDTH = 16
);
    logic                    in_active;
    logic [1:0]              in_sel;
    logic [PACKET_WIDTH-1:0] in_data;
    logic                    out_ready;
    logic                    out_valid;
    logic [PACKET_WIDTH-1:0] out_data;
    logic [1:0]              out_src;
    logic                    egress_full;
    logic                    misroute_err;
    logic [15:0]             pkt_count;
    logic [15:0]             drop_count;

    modport slave (
        input  in_active, in_sel, in_data, out_ready,
        output out_valid, out_data, out_src, egress_full, misroute_err, pkt_count, drop_count
    );

    modport master (
        output in_active, in_sel, in_data, out_ready,
        input  out_valid, out_data, out_src, egress_full, misroute_err, pkt_count, drop_count
    );
endinterface

// File: rtl/egress_buf.sv
// Egress packet FIFO: stores packet plus source port, head is read combinationally.
// Occupancy is DEPTH+1 bits; pointers wrap naturally since DEPTH is a power of two.
module egress_buf #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PACKET_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [PACKET_WIDTH-1:0] wr_data,
    input  logic [1:0]              wr_src,
    output logic [PACKET_WIDTH-1:0] rd_data,
    output logic [1:0]              rd_src,
    output logic [DEPTH:0]          count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = DEPTH + 1;

    logic [PACKET_WIDTH-1:0] mem_data [DEPTH];
    logic [1:0]              mem_src  [DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic                    do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    // NOTE: storage has no reset; validity is tracked by count, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= wr_data;
            mem_src[wr_ptr]  <= wr_src;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem_data[rd_ptr];
    assign rd_src  = mem_src[rd_ptr];

endmodule

// File: rtl/port_egress.sv
// Switch output egress: target decode, misroute/overflow drop, output FSM, optional stats.
// Define EGRESS_STATS_EN to build the saturating pkt_count/drop_count counters.
module port_egress
    import packet_pkg::*;
#(
    parameter int unsigned PORT_ID      = 0,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PACKET_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    port_egress_if.slave eg
);
    localparam int unsigned CNT_W = DEPTH + 1;

    egress_state_t           state, state_next;
    logic [3:0]              tgt;
    p_type                   ptype;
    logic                    accept, misroute, overflow, push, pop, full, out_valid;
    logic [PACKET_WIDTH-1:0] rd_data;
    logic [1:0]              rd_src;
    logic [DEPTH:0]          count;

    assign tgt   = eg.in_data[TGT_LSB +: PORTS];
    assign ptype = p_type'(eg.in_data[TYPE_LSB +: 2]);

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (state == E_SEND);
    assign pop       = out_valid && eg.out_ready;
    assign accept    = eg.in_active && (tgt[PORT_ID] || (ptype == P_BDP));
    assign misroute  = eg.in_active && (ptype != P_BDP) && !tgt[PORT_ID];
    // A full buffer still takes the packet when the head leaves in the same cycle.
    assign overflow  = accept && full && !pop;
    assign push      = accept && !overflow;

    egress_buf #(
        .DEPTH        (DEPTH),
        .PACKET_WIDTH (PACKET_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (eg.in_data),
        .wr_src  (eg.in_sel),
        .rd_data (rd_data),
        .rd_src  (rd_src),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= E_IDLE;
            eg.misroute_err  <= 1'b0;
        end else begin
            state            <= state_next;
            eg.misroute_err  <= misroute;
        end
    end

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            E_IDLE: if (count != '0) state_next = E_SEND;
            E_SEND: if (pop && !push && (count == CNT_W'(1))) state_next = E_IDLE;
            default: state_next = E_IDLE;
        endcase
    end

    // The head entry is presented directly, so it stays stable until popped.
    assign eg.out_valid   = out_valid;
    assign eg.out_data    = out_valid ? rd_data : '0;
    assign eg.out_src     = out_valid ? rd_src  : '0;
    // Asserted one slot early to absorb the registered crossbar mux after a grant.
    assign eg.egress_full = (count >= CNT_W'(DEPTH - 1));

`ifdef EGRESS_STATS_EN
    logic [15:0] pkt_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop && (pkt_cnt_q != 16'hFFFF))
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if ((misroute || overflow) && (drop_cnt_q != 16'hFFFF))
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign eg.pkt_count  = pkt_cnt_q;
    assign eg.drop_count = drop_cnt_q;
`else
    assign eg.pkt_count  = 16'd0;
    assign eg.drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_port_egress.sv
// Directed self-checking bench for port_egress (PORT_ID=2, DEPTH=4, 16-bit packets).
// Counter expectations follow EGRESS_STATS_EN: real counts when defined, zero otherwise.
module tb_port_egress;

    localparam int unsigned PW = 16;
`ifdef EGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    port_egress_if #(.PACKET_WIDTH(PW)) eg ();

    port_egress #(
        .PORT_ID      (2),
        .DEPTH        (4),
        .PACKET_WIDTH (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .eg    (eg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    logic [15:0] fill_data [4];
    logic [15:0] drain_data [4];
    logic [1:0]  drain_src  [4];

    initial begin
        fill_data  = '{16'h0041, 16'h0442, 16'h0844, 16'h0C48};
        drain_data = '{16'h0442, 16'h0844, 16'h0C48, 16'h1442};
        drain_src  = '{2'd1, 2'd2, 2'd3, 2'd3};

        eg.in_active = 1'b0;
        eg.in_sel    = 2'd0;
        eg.in_data   = '0;
        eg.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(eg.out_valid), 32'd0);
        check("rst_out_data", 32'(eg.out_data), 32'd0);
        check("rst_egress_full", 32'(eg.egress_full), 32'd0);
        check("rst_misroute", 32'(eg.misroute_err), 32'd0);
        check("rst_pkt_count", 32'(eg.pkt_count), 32'd0);
        check("rst_drop_count", 32'(eg.drop_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Unicast hit: presented one cycle after acceptance
        eg.in_active = 1'b1;
        eg.in_sel    = 2'd0;
        eg.in_data   = 16'h0041;
        tick();
        eg.in_active = 1'b0;
        check("uni_latency_not_yet", 32'(eg.out_valid), 32'd0);
        tick();
        check("uni_out_valid", 32'(eg.out_valid), 32'd1);
        check("uni_out_data", 32'(eg.out_data), 32'h0041);
        check("uni_out_src", 32'(eg.out_src), 32'd0);
        eg.out_ready = 1'b1;
        tick();
        eg.out_ready = 1'b0;
        check("uni_drained", 32'(eg.out_valid), 32'd0);
        check("uni_pkt_count", 32'(eg.pkt_count), 32'(cnt_exp(1)));

        // Misrouted unicast: dropped, one-cycle error pulse
        eg.in_active = 1'b1;
        eg.in_data   = 16'h0012;
        tick();
        eg.in_active = 1'b0;
        check("mis_pulse", 32'(eg.misroute_err), 32'd1);
        check("mis_no_full", 32'(eg.egress_full), 32'd0);
        tick();
        check("mis_pulse_end", 32'(eg.misroute_err), 32'd0);
        check("mis_no_write", 32'(eg.out_valid), 32'd0);
        check("mis_drop_count", 32'(eg.drop_count), 32'(cnt_exp(1)));

        // Fill with out_ready low; full flag from occupancy 3
        for (int i = 0; i < 4; i++) begin
            eg.in_active = 1'b1;
            eg.in_sel    = 2'(i);
            eg.in_data   = fill_data[i];
            tick();
            check($sformatf("fill_full_%0d", i + 1), 32'(eg.egress_full), 32'(i + 1 >= 3));
        end
        // Fifth packet overflows
        eg.in_data = 16'h1041;
        tick();
        eg.in_active = 1'b0;
        check("ovf_no_misroute", 32'(eg.misroute_err), 32'd0);
        check("ovf_drop_count", 32'(eg.drop_count), 32'(cnt_exp(2)));
        check("ovf_head_data", 32'(eg.out_data), 32'h0041);
        tick();
        check("hold_valid", 32'(eg.out_valid), 32'd1);
        check("hold_data", 32'(eg.out_data), 32'h0041);
        check("hold_src", 32'(eg.out_src), 32'd0);

        // Full buffer, push with same-cycle pop: accepted, occupancy stays 4
        eg.in_active = 1'b1;
        eg.in_sel    = 2'd3;
        eg.in_data   = 16'h1442;
        eg.out_ready = 1'b1;
        tick();
        eg.in_active = 1'b0;
        eg.out_ready = 1'b0;
        check("fullpop_b2b_data", 32'(eg.out_data), 32'h0442);
        check("fullpop_still_full", 32'(eg.egress_full), 32'd1);
        check("fullpop_no_drop", 32'(eg.drop_count), 32'(cnt_exp(2)));

        // Drain back-to-back; the accepted packet arrives last
        eg.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_valid_%0d", k), 32'(eg.out_valid), 32'd1);
            check($sformatf("drain_data_%0d", k), 32'(eg.out_data), 32'(drain_data[k]));
            check($sformatf("drain_src_%0d", k), 32'(eg.out_src), 32'(drain_src[k]));
            tick();
        end
        eg.out_ready = 1'b0;
        check("drain_empty", 32'(eg.out_valid), 32'd0);
        check("drain_not_full", 32'(eg.egress_full), 32'd0);
        check("drain_pkt_count", 32'(eg.pkt_count), 32'(cnt_exp(6)));

        // Broadcast with target bit clear is accepted
        eg.in_active = 1'b1;
        eg.in_sel    = 2'd1;
        eg.in_data   = 16'h0311;
        tick();
        eg.in_active = 1'b0;
        check("bdp_no_misroute", 32'(eg.misroute_err), 32'd0);
        tick();
        check("bdp_valid", 32'(eg.out_valid), 32'd1);
        check("bdp_data", 32'(eg.out_data), 32'h0311);
        check("bdp_src", 32'(eg.out_src), 32'd1);
        eg.out_ready = 1'b1;
        tick();
        eg.out_ready = 1'b0;
        check("bdp_delivered", 32'(eg.pkt_count), 32'(cnt_exp(7)));

        // Reset while presenting with 3 packets buffered
        for (int i = 0; i < 3; i++) begin
            eg.in_active = 1'b1;
            eg.in_sel    = 2'(i);
            eg.in_data   = fill_data[i];
            tick();
        end
        eg.in_active = 1'b0;
        check("prerst_valid", 32'(eg.out_valid), 32'd1);
        check("prerst_full", 32'(eg.egress_full), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(eg.out_valid), 32'd0);
        check("midrst_data", 32'(eg.out_data), 32'd0);
        check("midrst_full", 32'(eg.egress_full), 32'd0);
        check("midrst_pkt_count", 32'(eg.pkt_count), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("postrst_no_replay_%0d", i), 32'(eg.out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_egress.md
PORT_EGRESS -- requirements
Module: port_egress

Interface
REQ-001 SHALL have parameter PORT_ID, default 0, giving the switch output index 0..3 this egress serves.
REQ-002 SHALL have parameter DEPTH, default 4, giving the egress buffer depth in packets (power of two, minimum 2).
REQ-003 SHALL have parameter PACKET_WIDTH, default 16, giving the packet width in bits.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_active  in  1  crossbar output mux active; in_data is valid this cycle.
- in_sel  in  2  input port currently driving the mux.
- in_data  in  PACKET_WIDTH  packet from the crossbar mux.
- out_ready  in  1  downstream accepts a packet.
- out_valid  out  1  a packet is presented downstream.
- out_data  out  PACKET_WIDTH  presented packet.
- out_src  out  2  input port the presented packet came from.
- egress_full  out  1  backpressure to the arbiter; no grant is allowed to this output.
- misroute_err  out  1  one-cycle pulse when a misrouted packet is dropped.
- pkt_count  out  16  packets delivered (EGRESS_STATS_EN only).
- drop_count  out  16  packets dropped (EGRESS_STATS_EN only).

Function
REQ-005 SHALL decode packet fields as source = data[3:0] (one-hot), target = data[7:4] (one-hot), type = data[9:8] (p_type), payload = data[15:10].
REQ-006 SHALL accept a packet when in_active=1 and target[PORT_ID]=1, or type=BDP; accepted packets SHALL be stored with in_sel in the buffer.
REQ-007 SHALL drop a packet when in_active=1, type!=BDP and target[PORT_ID]=0, pulse misroute_err the next cycle, and not write the buffer.
REQ-008 SHALL drop a packet when in_active=1 and the buffer is full with no same-cycle downstream pop; this is an overflow and SHALL NOT pulse misroute_err.
REQ-009 SHALL accept the write when the buffer is full and a pop (out_valid and out_ready) occurs in the same cycle.
REQ-010 SHALL drive egress_full=1 when occupancy >= DEPTH-1, covering the one-cycle registered-mux latency after a grant.
REQ-011 SHALL implement the output FSM with states:
- E_IDLE: out_valid=0.
- E_SEND: out_valid=1.
REQ-012 SHALL make these FSM transitions:
- E_IDLE -> E_SEND when the buffer is non-empty.
- E_SEND -> E_IDLE on handshake when the buffer becomes empty.
- E_SEND stays in E_SEND otherwise.
REQ-013 SHALL give first-word latency of one cycle: a packet accepted into an empty buffer at edge N is presented with out_valid=1 after edge N+1.
REQ-014 SHALL hold out_data and out_src stable while out_valid=1 and out_ready=0.
REQ-015 SHALL present the next packet back-to-back in the cycle after a handshake, with no bubble, when the buffer holds more packets.
REQ-016 SHALL wrap buffer pointers modulo DEPTH, and SHALL keep occupancy DEPTH+1 bits wide with no overflow or underflow.
REQ-017 SHALL keep the buffer empty and out_valid at 0 when in_active=0 and the buffer is empty.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force state E_IDLE, pointers and occupancy to 0, out_valid=0, out_data=0, out_src=0, egress_full=0, misroute_err=0, pkt_count=0 and drop_count=0.
REQ-019 SHALL discard buffered packets when reset is asserted mid-transfer, and SHALL NOT replay them after reset.

Configuration
REQ-020 SHALL, with EGRESS_STATS_EN defined, increment pkt_count on each handshake and drop_count on each misroute or overflow drop; both counters SHALL saturate at 16'hFFFF.
REQ-021 SHALL, without EGRESS_STATS_EN, omit the counter logic and tie pkt_count and drop_count to 0.

Structure
REQ-022 SHALL take p_type (including BDP), egress state enum egress_state_t, and field offset constants from packet_pkg.
REQ-023 SHALL implement storage in one sub-module egress_buf (FIFO: push, pop, data, source, count); port_egress holds decode, drop logic, FSM and counters.

Verification
REQ-024 Bench scenario: PORT_ID=2, in_data=16'h0041 (target 4'b0100, source 4'b0001, unicast) -> out_valid=1 one cycle later with out_data=16'h0041; after handshake pkt_count=1.
REQ-025 Bench scenario: PORT_ID=2, in_data=16'h0012 unicast (target 4'b0001) -> no buffer write, misroute_err pulses once, drop_count=1.
REQ-026 Bench scenario: out_ready=0 with 4 accepted packets -> egress_full=1 from occupancy 3; a fifth packet is dropped and drop_count increments.
REQ-027 Bench scenario: buffer full, fifth packet arrives with out_ready=1 in the same cycle -> packet accepted, occupancy stays 4.
REQ-028 Bench scenario: BDP packet with target bit clear -> accepted and delivered.
REQ-029 Bench scenario: rst_n low while out_valid=1 and 3 packets buffered -> immediate out_valid=0; after release no packet is presented.
